// File: rtl/conv1x1_mc.sv
// rtl/conv1x1_mc.sv - streaming multi-channel 1x1 convolution with per-channel weights, bias, round and clamp
// Optional saturation flag output o_sat is enabled by defining CONV1X1_SAT_FLAG_EN.
module conv1x1_mc #(
  parameter int NUM_CH       = 3,
  parameter int WEIGHT_WIDTH = 16,
  parameter int FRAC_BITS    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clr,
  input  logic                         i_valid,
  input  logic [7:0]                   i_data,
  output logic                         i_ready,
  input  logic                         w_we,
  input  logic [$clog2(NUM_CH+1)-1:0]  w_addr,
  input  logic [WEIGHT_WIDTH-1:0]      w_data,
  output logic                         o_valid,
  output logic [7:0]                   o_data,
  input  logic                         o_ready
`ifdef CONV1X1_SAT_FLAG_EN
  ,
  output logic                         o_sat
`endif
);

  localparam int AW    = $clog2(NUM_CH + 1);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = 8 + WEIGHT_WIDTH + $clog2(NUM_CH) + 1;

  localparam logic [CH_W-1:0]         LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [AW-1:0]           BIAS_ADDR = AW'(NUM_CH);
  localparam logic [WEIGHT_WIDTH-1:0] W_ONE     = WEIGHT_WIDTH'(1) << FRAC_BITS;
  localparam logic signed [ACC_W-1:0] ROUND     = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] PIX_MAX   = ACC_W'(255);

  logic [WEIGHT_WIDTH-1:0] weight_q [NUM_CH];
  logic [WEIGHT_WIDTH-1:0] bias_q;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic                    o_valid_q, o_valid_d;
  logic [7:0]              o_data_q, o_data_d;

  logic [WEIGHT_WIDTH-1:0] w_sel;
  logic signed [ACC_W-1:0] pix_ext, w_ext, b_ext, prod, sum, res;
  logic [7:0]              clamped;
  logic                    accept, last;

`ifdef CONV1X1_SAT_FLAG_EN
  logic sat_q, sat_d, sat;
`endif

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) w_sel = weight_q[k];
    end
    pix_ext = {{(ACC_W-8){1'b0}}, i_data};
    w_ext   = {{(ACC_W-WEIGHT_WIDTH){w_sel[WEIGHT_WIDTH-1]}}, w_sel};
    b_ext   = {{(ACC_W-WEIGHT_WIDTH){bias_q[WEIGHT_WIDTH-1]}}, bias_q};
    prod    = pix_ext * w_ext;
    // Round half up in Q-format, then drop the fraction with an arithmetic shift.
    sum     = acc_q + prod + b_ext + ROUND;
    res     = sum >>> FRAC_BITS;
    if (res[ACC_W-1])        clamped = 8'd0;
    else if (res > PIX_MAX)  clamped = 8'hFF;
    else                     clamped = res[7:0];
  end

`ifdef CONV1X1_SAT_FLAG_EN
  assign sat = res[ACC_W-1] || (res > PIX_MAX);
`endif

  // Stall only while a finished result waits for the consumer; an abort blocks the accept.
  assign i_ready = !(o_valid_q && !o_ready) && !i_clr;
  assign accept  = i_valid && i_ready;
  assign last    = (ch_q == LAST_CH);

  always_comb begin
    acc_d     = acc_q;
    ch_d      = ch_q;
    o_valid_d = o_valid_q && !o_ready;
    o_data_d  = o_data_q;
`ifdef CONV1X1_SAT_FLAG_EN
    sat_d     = sat_q;
`endif
    if (i_clr) begin
      acc_d = '0;
      ch_d  = '0;
    end else if (accept) begin
      if (last) begin
        acc_d     = '0;
        ch_d      = '0;
        o_valid_d = 1'b1;
        o_data_d  = clamped;
`ifdef CONV1X1_SAT_FLAG_EN
        sat_d     = sat;
`endif
      end else begin
        acc_d = acc_q + prod;
        ch_d  = ch_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      ch_q      <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      bias_q    <= '0;
      for (int k = 0; k < NUM_CH; k++) weight_q[k] <= W_ONE;
`ifdef CONV1X1_SAT_FLAG_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      acc_q     <= acc_d;
      ch_q      <= ch_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
`ifdef CONV1X1_SAT_FLAG_EN
      sat_q     <= sat_d;
`endif
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_we && w_addr == AW'(k)) weight_q[k] <= w_data;
      end
      if (w_we && w_addr == BIAS_ADDR) bias_q <= w_data;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
`ifdef CONV1X1_SAT_FLAG_EN
  assign o_sat   = sat_q;
`endif

endmodule

// File: tb/tb_conv1x1_mc.sv
// tb/tb_conv1x1_mc.sv - directed table-driven bench for conv1x1_mc (NUM_CH=3, Q8.8 coefficients)
module tb_conv1x1_mc;

  logic        clk = 1'b0;
  logic        rst, i_clr, i_valid, i_ready;
  logic [7:0]  i_data;
  logic        w_we;
  logic [1:0]  w_addr;
  logic [15:0] w_data;
  logic        o_valid, o_ready;
  logic [7:0]  o_data;
`ifdef CONV1X1_SAT_FLAG_EN
  logic        o_sat;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv1x1_mc #(.NUM_CH(3), .WEIGHT_WIDTH(16), .FRAC_BITS(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (i_clr),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_ready (i_ready),
    .w_we    (w_we),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_ready (o_ready)
`ifdef CONV1X1_SAT_FLAG_EN
    ,
    .o_sat   (o_sat)
`endif
  );

  typedef struct {
    logic [7:0]  d0, d1, d2;
    logic [15:0] w0, w1, w2, bias;
    logic [7:0]  exp_data;
    logic        exp_sat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [15:0] data);
    w_we = 1'b1; w_addr = addr; w_data = data;
    step();
    w_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    i_valid = 1'b1; i_data = d;
    #1;
    check("send_i_ready", int'(i_ready), 1);
    step();
    i_valid = 1'b0;
  endtask

  task automatic pixel(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); send(b); send(c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // {d0,d1,d2, w0,w1,w2, bias, exp_data, exp_sat}
    vecs[0] = '{8'd10,  8'd20,  8'd30, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 8'd60,  1'b0};
    vecs[1] = '{8'd1,   8'd0,   8'd0,  16'h0080, 16'h0080, 16'h0080, 16'h0000, 8'd1,   1'b0};
    vecs[2] = '{8'd0,   8'd0,   8'd0,  16'h0080, 16'h0080, 16'h0080, 16'h0000, 8'd0,   1'b0};
    vecs[3] = '{8'd100, 8'd0,   8'd0,  16'hFF00, 16'h0100, 16'h0100, 16'h0000, 8'd0,   1'b1};
    vecs[4] = '{8'd200, 8'd200, 8'd0,  16'h0200, 16'h0200, 16'h0200, 16'h0000, 8'd255, 1'b1};
    vecs[5] = '{8'd1,   8'd2,   8'd3,  16'h0100, 16'h0100, 16'h0100, 16'h0500, 8'd11,  1'b0};
    vecs[6] = '{8'd3,   8'd3,   8'd3,  16'h0100, 16'h0100, 16'h0100, 16'hF600, 8'd0,   1'b1};
    vecs[7] = '{8'd3,   8'd0,   8'd0,  16'h0080, 16'h0080, 16'h0080, 16'h0000, 8'd2,   1'b0};
    vecs[8] = '{8'd1,   8'd0,   8'd0,  16'h0040, 16'h0040, 16'h0040, 16'h0000, 8'd0,   1'b0};

    rst = 1'b1; i_clr = 1'b0; i_valid = 1'b0; i_data = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0; o_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    check("reset_i_ready", int'(i_ready), 1);
    check("reset_o_valid", int'(o_valid), 0);
    check("reset_o_data", int'(o_data), 0);
`ifdef CONV1X1_SAT_FLAG_EN
    check("reset_o_sat", int'(o_sat), 0);
`endif

    // Default coefficients, latency, and back-to-back pixels.
    send(8'd10); send(8'd20);
    check("lat_not_yet", int'(o_valid), 0);
    send(8'd30);
    check("def_o_valid", int'(o_valid), 1);
    check("def_o_data", int'(o_data), 60);
    send(8'd1);
    check("def_valid_1cyc", int'(o_valid), 0);
    send(8'd2); send(8'd3);
    check("b2b_o_valid", int'(o_valid), 1);
    check("b2b_o_data", int'(o_data), 6);
    step();
    check("b2b_drop", int'(o_valid), 0);

    for (int i = 0; i < 9; i++) begin
      wr(2'd0, vecs[i].w0);
      wr(2'd1, vecs[i].w1);
      wr(2'd2, vecs[i].w2);
      wr(2'd3, vecs[i].bias);
      pixel(vecs[i].d0, vecs[i].d1, vecs[i].d2);
      check($sformatf("vec%0d_o_valid", i), int'(o_valid), 1);
      check($sformatf("vec%0d_o_data", i), int'(o_data), int'(vecs[i].exp_data));
`ifdef CONV1X1_SAT_FLAG_EN
      check($sformatf("vec%0d_o_sat", i), int'(o_sat), int'(vecs[i].exp_sat));
`endif
    end

    // Backpressure: result held, input stalled, release while presenting next sample.
    do_reset();
    o_ready = 1'b0;
    pixel(8'd1, 8'd2, 8'd3);
    i_valid = 1'b1; i_data = 8'd7;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("hold_i_ready", int'(i_ready), 0);
      check("hold_o_valid", int'(o_valid), 1);
      check("hold_o_data", int'(o_data), 6);
      step();
    end
    o_ready = 1'b1;
    #1;
    check("release_i_ready", int'(i_ready), 1);
    step();
    check("release_drop", int'(o_valid), 0);
    send(8'd8); send(8'd9);
    check("after_hold_valid", int'(o_valid), 1);
    check("after_hold_data", int'(o_data), 24);

    // Abort mid-pixel.
    send(8'd9); send(8'd9);
    i_valid = 1'b1; i_data = 8'd100; i_clr = 1'b1;
    #1;
    check("clr_i_ready", int'(i_ready), 0);
    step();
    i_clr = 1'b0; i_valid = 1'b0;
    pixel(8'd5, 8'd5, 8'd5);
    check("clr_o_valid", int'(o_valid), 1);
    check("clr_o_data", int'(o_data), 15);

    // Reset mid-pixel, also reverting a weight write.
    wr(2'd0, 16'h0200);
    o_ready = 1'b0;
    send(8'd9); send(8'd9);
    do_reset();
    o_ready = 1'b1;
    #1;
    check("rst_o_valid", int'(o_valid), 0);
    check("rst_i_ready", int'(i_ready), 1);
    pixel(8'd5, 8'd5, 8'd5);
    check("rst_o_data", int'(o_data), 15);

    // Coefficient write in the same cycle as the sample that uses it.
    send(8'd10);
    i_valid = 1'b1; i_data = 8'd50;
    w_we = 1'b1; w_addr = 2'd1; w_data = 16'h0000;
    #1;
    check("wsame_i_ready", int'(i_ready), 1);
    step();
    w_we = 1'b0; i_valid = 1'b0;
    send(8'd0);
    check("wsame_old_data", int'(o_data), 60);
    pixel(8'd10, 8'd50, 8'd0);
    check("wsame_new_data", int'(o_data), 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
